mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit; the consumer end of the EX/MEM pipeline register outputs.
- Turns one registered memory op (address, store data, byte-enable size mask, load extend op) into a single-outstanding req/addr_ok/data_ok transaction on the data bus.
- Holds the pipeline via suspend until the transaction completes.
- Returns the aligned, extended load data to the writeback path.

Parameters:
- STALL_CNT_W, 32, width of the saturating stall-cycle performance counter

Ports:
- cpu_clk  in  1  clock; one clock domain, all state on rising edge
- cpu_rstn  in  1  asynchronous, active-low reset
- valid_in  in  1  MEM-stage instruction valid
- ram_we_in  in  4  unshifted store size mask: 0001 byte, 0011 half, 1111 word; 0000 means not a store
- mem_rd_in  in  1  instruction is a load
- ram_ext_op_in  in  3  load extend op (package encodings)
- addr_in  in  32  effective address (alu_C)
- wdata_in  in  32  store data in low bits (rD2)
- suspend  out  1  pipeline hold; combinational
- rdata_out  out  32  extended load data, registered
- ale_out  out  1  misaligned-access pulse, registered
- dbus_req  out  1  request, registered
- dbus_wr  out  1  1 = write, registered
- dbus_wstrb  out  4  byte strobes, shifted by addr[1:0]
- dbus_addr  out  32  word-aligned address, addr_in & ~3
- dbus_wdata  out  32  replicated store data
- dbus_addr_ok  in  1  request accepted
- dbus_data_ok  in  1  read data valid / write done
- dbus_rdata  in  32  read word
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with suspend=1

Behaviour:
- Reset values: FSM IDLE; dbus_req, dbus_wr, ale_out = 0; dbus_wstrb = 0; dbus_addr, dbus_wdata, rdata_out, stall_cnt = 0. suspend is 0 during reset.
- Access condition: acc = valid_in & (mem_rd_in | ram_we_in != 0). mem_rd_in and a nonzero ram_we_in together are illegal; mem_rd_in takes priority.
- Misaligned access:
  - half with addr[0]=1, or word with addr[1:0]!=0.
  - Behaves as one DONE cycle: no bus request, ale_out=1 for that cycle, rdata_out unchanged.
  - Size comes from ram_we_in for stores and from ram_ext_op_in for loads.
- FSM states IDLE, ADDR, DATA, DONE:
  - IDLE & acc & aligned → ADDR. Register dbus_req=1 and all bus fields.
  - IDLE & acc & misaligned → DONE with ale_out=1.
  - ADDR: hold req and all fields stable until dbus_addr_ok=1 is sampled. On that edge drop req → DATA.
  - DATA: wait for dbus_data_ok. On that edge capture the extended dbus_rdata into rdata_out (loads only) → DONE.
  - DONE: inputs ignored, because they still hold the same instruction → IDLE. ale_out clears.
- suspend = acc & (state != DONE).
  - The pipeline advances at the end of DONE. Minimum load/store latency is 4 cycles (IDLE, ADDR, DATA, DONE) when addr_ok and data_ok arrive on the first opportunity.
  - No-access instructions see suspend=0 in IDLE and pass in 1 cycle.
- dbus_data_ok outside DATA and dbus_addr_ok outside ADDR are ignored. Only one transaction is outstanding at a time.
- Store lanes: dbus_wstrb = ram_we_in << addr[1:0]. dbus_wdata is {4{b}} for byte, {2{h}} for half, w for word.
- Load extract:
  - byte = rdata >> 8*addr[1:0]; half = rdata >> 16*addr[1].
  - EXT_B sign-extends 8, EXT_BU zero-extends 8, EXT_H sign-extends 16, EXT_HU zero-extends 16, EXT_W passes 32.
  - Undefined encodings pass 32.
- stall_cnt increments each cycle suspend=1 and saturates at all-ones.
- Reset mid-transaction: immediate return to IDLE and req drops. Any late data_ok is ignored. The bus slave shares cpu_rstn.

Decomposition:
- Shared package/defines: EXT_B=3'd0, EXT_BU=3'd1, EXT_H=3'd2, EXT_HU=3'd3, EXT_W=3'd4; size masks; FSM state codes (2 bits).
- One combinational sub-module, load_ext (addr[1:0], ext_op, word → 32-bit result), reusable by other units.

Test Plan:
- Load word: ld.w at addr 0x100, addr_ok on the first ADDR cycle, data_ok 2 cycles later with rdata 0xDEADBEEF → rdata_out=0xDEADBEEF; suspend high for exactly the IDLE, ADDR and 2 DATA cycles.
- Byte store: st.b addr 0x203, wdata 0x000000A5, ram_we 0001 → dbus_wstrb=1000, dbus_wdata=0xA5A5A5A5, dbus_addr=0x200.
- Sign/zero extend: rdata 0x80FF7F01 at addr offset 2 → EXT_H gives 0xFFFF80FF, EXT_HU gives 0x000080FF. At offset 1, EXT_B gives 0x0000007F.
- Misaligned: ld.w addr 0x102 → no dbus_req, ale_out pulses 1 cycle, suspend=1 for 1 cycle.
- addr_ok delayed 5 cycles → req and all fields stable throughout; a spurious data_ok during ADDR is ignored; stall_cnt increases by the exact cycle count.
- Reset asserted in DATA → all outputs return to reset values asynchronously; data_ok after release is ignored; a following non-memory instruction sees suspend=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: extend ops, size masks
// and FSM state codes.
package mem_access_unit_pkg;

  localparam logic [2:0] EXT_B  = 3'd0;
  localparam logic [2:0] EXT_BU = 3'd1;
  localparam logic [2:0] EXT_H  = 3'd2;
  localparam logic [2:0] EXT_HU = 3'd3;
  localparam logic [2:0] EXT_W  = 3'd4;

  localparam logic [3:0] SIZE_NONE = 4'b0000;
  localparam logic [3:0] SIZE_B    = 4'b0001;
  localparam logic [3:0] SIZE_H    = 4'b0011;
  localparam logic [3:0] SIZE_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } mau_state_e;

  // Store data is replicated across the lanes so the strobes alone select bytes.
  function automatic logic [31:0] replicate_wdata(input logic [3:0] size,
                                                  input logic [31:0] d);
    case (size)
      SIZE_B:  return {4{d[7:0]}};
      SIZE_H:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load data alignment and sign/zero extension; purely combinational so any
// unit that reads a memory word can reuse it.
module load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ext_op,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_x;
  logic signed [31:0] half_x;

  always_comb begin
    byte_s = word[{addr_lo, 3'b000} +: 8];
    half_s = addr_lo[1] ? word[31:16] : word[15:0];
    byte_x = byte_s;
    half_x = half_s;
    case (ext_op)
      EXT_B:   result = byte_x;
      EXT_BU:  result = {24'h000000, byte_s};
      EXT_H:   result = half_x;
      EXT_HU:  result = {16'h0000, half_s};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one req/addr_ok/data_ok bus transaction per
// memory instruction and holds the pipeline with suspend until it completes.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic                   valid_in,
  input  logic [3:0]             ram_we_in,
  input  logic                   mem_rd_in,
  input  logic [2:0]             ram_ext_op_in,
  input  logic [31:0]            addr_in,
  input  logic [31:0]            wdata_in,
  output logic                   suspend,
  output logic [31:0]            rdata_out,
  output logic                   ale_out,
  output logic                   dbus_req,
  output logic                   dbus_wr,
  output logic [3:0]             dbus_wstrb,
  output logic [31:0]            dbus_addr,
  output logic [31:0]            dbus_wdata,
  input  logic                   dbus_addr_ok,
  input  logic                   dbus_data_ok,
  input  logic [31:0]            dbus_rdata,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  mau_state_e  state_q, state_d;
  logic        acc;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        issue;
  logic        ale_set;
  logic        ld_q;
  logic [1:0]  off_q;
  logic [2:0]  ext_q;
  logic [31:0] ext_data;

  assign acc     = valid_in & (mem_rd_in | (ram_we_in != SIZE_NONE));
  assign suspend = cpu_rstn & acc & (state_q != ST_DONE);

  // Loads take their access size from the extend op; undefined ops act as word.
  always_comb begin
    if (mem_rd_in) begin
      is_half = (ram_ext_op_in == EXT_H) || (ram_ext_op_in == EXT_HU);
      is_word = (ram_ext_op_in != EXT_B) && (ram_ext_op_in != EXT_BU) && !is_half;
    end else begin
      is_half = (ram_we_in == SIZE_H);
      is_word = (ram_we_in == SIZE_W);
    end
    misaligned = (is_half & addr_in[0]) | (is_word & (addr_in[1:0] != 2'b00));
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    ale_set = 1'b0;
    case (state_q)
      ST_IDLE: if (acc) begin
        if (misaligned) begin
          state_d = ST_DONE;
          ale_set = 1'b1;
        end else begin
          state_d = ST_ADDR;
          issue   = 1'b1;
        end
      end
      ST_ADDR: if (dbus_addr_ok) state_d = ST_DATA;
      ST_DATA: if (dbus_data_ok) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus fields are captured at issue and held until the next issue.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      dbus_req   <= 1'b0;
      dbus_wr    <= 1'b0;
      dbus_wstrb <= 4'b0000;
      dbus_addr  <= 32'h0;
      dbus_wdata <= 32'h0;
      rdata_out  <= 32'h0;
      ale_out    <= 1'b0;
      ld_q       <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      ale_out <= ale_set;
      if (suspend) stall_cnt <= sat_inc(stall_cnt);
      if (issue) begin
        dbus_req   <= 1'b1;
        dbus_wr    <= ~mem_rd_in;
        dbus_wstrb <= mem_rd_in ? 4'b0000 : (ram_we_in << addr_in[1:0]);
        dbus_addr  <= {addr_in[31:2], 2'b00};
        dbus_wdata <= replicate_wdata(ram_we_in, wdata_in);
        ld_q       <= mem_rd_in;
      end
      if (state_q == ST_ADDR && dbus_addr_ok) dbus_req <= 1'b0;
      if (state_q == ST_DATA && dbus_data_ok && ld_q) rdata_out <= ext_data;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (issue) begin
      off_q <= addr_in[1:0];
      ext_q <= ram_ext_op_in;
    end
  end

  load_ext u_load_ext (
    .addr_lo (off_q),
    .ext_op  (ext_q),
    .word    (dbus_rdata),
    .result  (ext_data)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, extension, misalignment,
// slow slave and reset during a transaction.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic        valid_in;
  logic [3:0]  ram_we_in;
  logic        mem_rd_in;
  logic [2:0]  ram_ext_op_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        suspend;
  logic [31:0] rdata_out;
  logic        ale_out;
  logic        dbus_req;
  logic        dbus_wr;
  logic [3:0]  dbus_wstrb;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_addr_ok;
  logic        dbus_data_ok;
  logic [31:0] dbus_rdata;
  logic [31:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;
  int susp_n = 0;

  mem_access_unit #(.STALL_CNT_W(32)) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rstn      (cpu_rstn),
    .valid_in      (valid_in),
    .ram_we_in     (ram_we_in),
    .mem_rd_in     (mem_rd_in),
    .ram_ext_op_in (ram_ext_op_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .suspend       (suspend),
    .rdata_out     (rdata_out),
    .ale_out       (ale_out),
    .dbus_req      (dbus_req),
    .dbus_wr       (dbus_wr),
    .dbus_wstrb    (dbus_wstrb),
    .dbus_addr     (dbus_addr),
    .dbus_wdata    (dbus_wdata),
    .dbus_addr_ok  (dbus_addr_ok),
    .dbus_data_ok  (dbus_data_ok),
    .dbus_rdata    (dbus_rdata),
    .stall_cnt     (stall_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    #1;
    if (suspend) susp_n++;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [3:0] we, input logic [2:0] ext,
                       input logic [31:0] addr, input logic [31:0] wd);
    valid_in      = 1'b1;
    mem_rd_in     = rd;
    ram_we_in     = we;
    ram_ext_op_in = ext;
    addr_in       = addr;
    wdata_in      = wd;
    susp_n        = 0;
  endtask

  task automatic idle_in();
    valid_in      = 1'b0;
    mem_rd_in     = 1'b0;
    ram_we_in     = 4'b0000;
    ram_ext_op_in = EXT_W;
    addr_in       = 32'h0;
    wdata_in      = 32'h0;
  endtask

  // Full transaction with addr_ok on the first ADDR cycle; ends in DONE.
  task automatic txn(input string tag, input logic rd, input logic [3:0] we,
                     input logic [2:0] ext, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rword, input logic [31:0] e_addr,
                     input logic [31:0] e_strb, input logic [31:0] e_wdata, input int d_dly);
    drive(rd, we, ext, addr, wd);
    tick();
    chk({tag, "_req"},   32'(dbus_req), 32'd1);
    chk({tag, "_wr"},    32'(dbus_wr), 32'(!rd));
    chk({tag, "_addr"},  dbus_addr, e_addr);
    chk({tag, "_wstrb"}, 32'(dbus_wstrb), e_strb);
    chk({tag, "_wdata"}, dbus_wdata, e_wdata);
    dbus_addr_ok = 1'b1;
    tick();
    dbus_addr_ok = 1'b0;
    chk({tag, "_req_drop"}, 32'(dbus_req), 32'd0);
    repeat (d_dly) tick();
    dbus_data_ok = 1'b1;
    dbus_rdata   = rword;
    tick();
    dbus_data_ok = 1'b0;
    chk({tag, "_susp_done"}, 32'(suspend), 32'd0);
  endtask

  initial begin
    cpu_rstn     = 1'b0;
    dbus_addr_ok = 1'b0;
    dbus_data_ok = 1'b0;
    dbus_rdata   = 32'h0;
    idle_in();
    valid_in  = 1'b1;
    mem_rd_in = 1'b1;
    #12;
    chk("rst_susp",  32'(suspend), 32'd0);
    chk("rst_req",   32'(dbus_req), 32'd0);
    chk("rst_rdata", rdata_out, 32'h0);
    chk("rst_stall", stall_cnt, 32'h0);
    chk("rst_ale",   32'(ale_out), 32'd0);
    idle_in();
    @(posedge cpu_clk);
    #1;
    cpu_rstn = 1'b1;
    tick();

    // Word load, data_ok one cycle late
    txn("ldw", 1'b1, SIZE_NONE, EXT_W, 32'h100, 32'h0, 32'hDEADBEEF,
        32'h100, 32'h0, 32'h0, 1);
    chk("ldw_rdata", rdata_out, 32'hDEADBEEF);
    chk("ldw_susp_cycles", susp_n, 32'd4);
    chk("ldw_stall", stall_cnt, 32'd4);
    idle_in(); tick();

    txn("stb", 1'b0, SIZE_B, EXT_W, 32'h203, 32'h000000A5, 32'h0,
        32'h200, 32'h8, 32'hA5A5A5A5, 0);
    chk("stb_rdata_keep", rdata_out, 32'hDEADBEEF);
    chk("stb_susp_cycles", susp_n, 32'd3);
    chk("stb_stall", stall_cnt, 32'd7);
    idle_in(); tick();

    txn("sth", 1'b0, SIZE_H, EXT_W, 32'h102, 32'h1234ABCD, 32'h0,
        32'h100, 32'hC, 32'hABCDABCD, 0);
    chk("sth_stall", stall_cnt, 32'd10);
    idle_in(); tick();

    txn("ldh", 1'b1, SIZE_NONE, EXT_H, 32'h402, 32'h0, 32'h80FF7F01,
        32'h400, 32'h0, 32'h0, 0);
    chk("ldh_rdata", rdata_out, 32'hFFFF80FF);
    idle_in(); tick();

    txn("ldhu", 1'b1, SIZE_NONE, EXT_HU, 32'h402, 32'h0, 32'h80FF7F01,
        32'h400, 32'h0, 32'h0, 0);
    chk("ldhu_rdata", rdata_out, 32'h000080FF);
    idle_in(); tick();

    txn("ldb1", 1'b1, SIZE_NONE, EXT_B, 32'h401, 32'h0, 32'h80FF7F01,
        32'h400, 32'h0, 32'h0, 0);
    chk("ldb1_rdata", rdata_out, 32'h0000007F);
    idle_in(); tick();

    txn("ldb3", 1'b1, SIZE_NONE, EXT_B, 32'h403, 32'h0, 32'h80FF7F01,
        32'h400, 32'h0, 32'h0, 0);
    chk("ldb3_rdata", rdata_out, 32'hFFFFFF80);
    chk("ldb3_stall", stall_cnt, 32'd22);
    idle_in(); tick();

    // Misaligned word load: one-cycle DONE with ale pulse
    drive(1'b1, SIZE_NONE, EXT_W, 32'h102, 32'h0);
    tick();
    chk("mis_ld_req",   32'(dbus_req), 32'd0);
    chk("mis_ld_ale",   32'(ale_out), 32'd1);
    chk("mis_ld_susp",  32'(suspend), 32'd0);
    chk("mis_ld_cyc",   susp_n, 32'd1);
    chk("mis_ld_rdata", rdata_out, 32'hFFFFFF80);
    idle_in(); tick();
    chk("mis_ld_ale_clr", 32'(ale_out), 32'd0);

    drive(1'b0, SIZE_W, EXT_W, 32'h201, 32'h11223344);
    tick();
    chk("mis_st_req", 32'(dbus_req), 32'd0);
    chk("mis_st_ale", 32'(ale_out), 32'd1);
    chk("mis_st_stall", stall_cnt, 32'd24);
    idle_in(); tick();

    // Slow slave: addr_ok after 5 waiting cycles, spurious data_ok in ADDR
    drive(1'b0, SIZE_W, EXT_W, 32'h300, 32'hCAFEF00D);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("slow_req",   32'(dbus_req), 32'd1);
      chk("slow_addr",  dbus_addr, 32'h300);
      chk("slow_wstrb", 32'(dbus_wstrb), 32'hF);
      chk("slow_wdata", dbus_wdata, 32'hCAFEF00D);
      dbus_data_ok = (i == 2);
      tick();
    end
    dbus_data_ok = 1'b0;
    chk("slow_req_hold", 32'(dbus_req), 32'd1);
    dbus_addr_ok = 1'b1;
    tick();
    dbus_addr_ok = 1'b0;
    chk("slow_req_drop", 32'(dbus_req), 32'd0);
    chk("slow_susp_data", 32'(suspend), 32'd1);
    dbus_data_ok = 1'b1;
    tick();
    dbus_data_ok = 1'b0;
    chk("slow_susp_done", 32'(suspend), 32'd0);
    chk("slow_susp_cycles", susp_n, 32'd8);
    chk("slow_stall", stall_cnt, 32'd32);
    idle_in(); tick();

    // Reset while waiting in DATA
    drive(1'b1, SIZE_NONE, EXT_W, 32'h500, 32'h0);
    tick();
    dbus_addr_ok = 1'b1;
    tick();
    dbus_addr_ok = 1'b0;
    #2;
    cpu_rstn = 1'b0;
    #1;
    chk("rstd_susp",  32'(suspend), 32'd0);
    chk("rstd_addr",  dbus_addr, 32'h0);
    chk("rstd_rdata", rdata_out, 32'h0);
    chk("rstd_stall", stall_cnt, 32'h0);
    chk("rstd_req",   32'(dbus_req), 32'd0);
    idle_in();
    @(posedge cpu_clk);
    #1;
    cpu_rstn     = 1'b1;
    dbus_data_ok = 1'b1;
    dbus_rdata   = 32'h12345678;
    tick();
    dbus_data_ok = 1'b0;
    chk("late_dok_rdata", rdata_out, 32'h0);
    chk("late_dok_req",   32'(dbus_req), 32'd0);
    valid_in = 1'b1;
    #1;
    chk("nomem_susp", 32'(suspend), 32'd0);
    tick();
    chk("nomem_req",   32'(dbus_req), 32'd0);
    chk("nomem_stall", stall_cnt, 32'h0);
    idle_in(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
